imm_gen_pipe: RTL and testbench

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pkg.sv | 34 +++
 rtl/imm_gen_pipe_if.sv | 26 ++
 rtl/imm_gen_dec.sv | 85 ++++++++
 rtl/imm_gen_pipe.sv | 107 ++++++++++
 tb/tb_imm_gen_pipe.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/imm_gen_pkg.sv
// Shared types and opcode constants for the pipelined RISC-V immediate generator.
package imm_gen_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned OPC_W  = 7;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_J    = 3'd4,
        FMT_U    = 3'd5,
        FMT_Z    = 3'd6,
        FMT_C    = 3'd7
    } imm_fmt_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Valid/ready instruction-in, decoded-immediate-out bus for imm_gen_pipe.
interface imm_gen_pipe_if #(
    parameter int unsigned XLEN = 32
);
    import imm_gen_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [INST_W-1:0]   in_inst;
    logic                out_valid;
    logic                out_ready;
    logic [XLEN-1:0]     out_imm;
    imm_fmt_e            out_fmt;
    logic                out_illegal;

    modport master (
        output in_valid, in_inst, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal
    );

    modport slave (
        input  in_valid, in_inst, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal
    );

endinterface

// File: rtl/imm_gen_dec.sv
// Combinational immediate decoder. Compressed (RVC) decode is compiled in only
// when IMM_GEN_RVC_EN is defined; otherwise every 16-bit encoding is illegal.
module imm_gen_dec
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [INST_W-1:0] inst,
    output logic [XLEN-1:0]   imm,
    output imm_fmt_e          fmt,
    output logic              illegal
);

    always_comb begin
        imm     = '0;
        fmt     = FMT_NONE;
        illegal = 1'b1;
        if (inst[1:0] == 2'b11) begin
            case (inst[6:0])
                OPC_LOAD, OPC_OPIMM, OPC_JALR: begin
                    fmt     = FMT_I;
                    imm     = XLEN'($signed(inst[31:20]));
                    illegal = 1'b0;
                end
                OPC_STORE: begin
                    fmt     = FMT_S;
                    imm     = XLEN'($signed({inst[31:25], inst[11:7]}));
                    illegal = 1'b0;
                end
                OPC_BRANCH: begin
                    fmt     = FMT_B;
                    imm     = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
                    illegal = 1'b0;
                end
                OPC_JAL: begin
                    fmt     = FMT_J;
                    imm     = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
                    illegal = 1'b0;
                end
                OPC_LUI, OPC_AUIPC: begin
                    fmt     = FMT_U;
                    imm     = XLEN'($signed({inst[31:12], 12'b0}));
                    illegal = 1'b0;
                end
                OPC_SYSTEM: begin
                    // Only the CSR*I forms carry an immediate (uimm in rs1 field)
                    illegal = 1'b0;
                    if (inst[14]) begin
                        fmt = FMT_Z;
                        imm = XLEN'(inst[19:15]);
                    end
                end
                default: ;
            endcase
        end else begin
`ifdef IMM_GEN_RVC_EN
            if (inst[1:0] == 2'b01) begin
                case (inst[15:13])
                    3'b000, 3'b010: begin
                        fmt     = FMT_C;
                        imm     = XLEN'($signed({inst[12], inst[6:2]}));
                        illegal = 1'b0;
                    end
                    3'b101: begin
                        fmt     = FMT_C;
                        imm     = XLEN'($signed({inst[12], inst[8], inst[10:9], inst[6], inst[7],
                                                 inst[2], inst[11], inst[5:3], 1'b0}));
                        illegal = 1'b0;
                    end
                    3'b110, 3'b111: begin
                        fmt     = FMT_C;
                        imm     = XLEN'($signed({inst[12], inst[6:5], inst[2], inst[11:10],
                                                 inst[4:3], 1'b0}));
                        illegal = 1'b0;
                    end
                    default: ;
                endcase
            end
`else
            illegal = 1'b1;
`endif
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator behind a 2-entry skid buffer: one-cycle latency, in_ready
// driven from a register so there is no combinational path from out_ready.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    imm_gen_pipe_if.slave  bus
);

    logic [XLEN-1:0] dec_imm;
    imm_fmt_e        dec_fmt;
    logic            dec_illegal;

    imm_gen_dec #(.XLEN(XLEN)) u_dec (
        .inst    (bus.in_inst),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    skid_state_e     state_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic [XLEN-1:0] head_imm_q;
    imm_fmt_e        head_fmt_q;
    logic            head_ill_q;
    logic [XLEN-1:0] skid_imm_q;
    imm_fmt_e        skid_fmt_q;
    logic            skid_ill_q;

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = bus.in_valid & in_ready_q;
    assign out_xfer = out_valid_q & bus.out_ready;

    // Head register drives the output; skid register catches the word that
    // arrives while the head is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            head_imm_q  <= '0;
            head_fmt_q  <= FMT_NONE;
            head_ill_q  <= 1'b0;
            skid_imm_q  <= '0;
            skid_fmt_q  <= FMT_NONE;
            skid_ill_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    in_ready_q <= 1'b1;
                    if (in_xfer) begin
                        head_imm_q  <= dec_imm;
                        head_fmt_q  <= dec_fmt;
                        head_ill_q  <= dec_illegal;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    in_ready_q <= 1'b1;
                    if (in_xfer && !out_xfer) begin
                        skid_imm_q <= dec_imm;
                        skid_fmt_q <= dec_fmt;
                        skid_ill_q <= dec_illegal;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_FULL;
                    end else if (in_xfer && out_xfer) begin
                        head_imm_q <= dec_imm;
                        head_fmt_q <= dec_fmt;
                        head_ill_q <= dec_illegal;
                    end else if (out_xfer) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    in_ready_q <= 1'b0;
                    if (out_xfer) begin
                        head_imm_q <= skid_imm_q;
                        head_fmt_q <= skid_fmt_q;
                        head_ill_q <= skid_ill_q;
                        in_ready_q <= 1'b1;
                        state_q    <= ST_ONE;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    state_q     <= ST_EMPTY;
                end
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_imm     = head_imm_q;
    assign bus.out_fmt     = head_fmt_q;
    assign bus.out_illegal = head_ill_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe at XLEN=32 and XLEN=64.
module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32)) bus32 ();
    imm_gen_pipe_if #(.XLEN(64)) bus64 ();

    imm_gen_pipe #(.XLEN(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));
    imm_gen_pipe #(.XLEN(64)) u_dut64 (.clk(clk), .rst_n(rst_n), .bus(bus64.slave));

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    vec_t v32[10];
    vec_t v64[3];

    task automatic check32(input string tag, input vec_t v);
        check({tag, "_valid"}, 64'(bus32.out_valid), 64'(1'b1));
        check({tag, "_imm"},   64'(bus32.out_imm),   64'(v.imm[31:0]));
        check({tag, "_fmt"},   64'(bus32.out_fmt),   64'(v.fmt));
        check({tag, "_ill"},   64'(bus32.out_illegal), 64'(v.ill));
    endtask

    initial begin
        v32[0] = '{"addi_m1", 32'hFFF00093, 64'hFFFFFFFF, 3'(FMT_I), 1'b0};
        v32[1] = '{"beq_m4",  32'hFE000EE3, 64'hFFFFFFFC, 3'(FMT_B), 1'b0};
        v32[2] = '{"sw_m8",   32'hFE20AC23, 64'hFFFFFFF8, 3'(FMT_S), 1'b0};
        v32[3] = '{"jal_p8",  32'h0080006F, 64'h00000008, 3'(FMT_J), 1'b0};
        v32[4] = '{"auipc",   32'h12345017, 64'h12345000, 3'(FMT_U), 1'b0};
        v32[5] = '{"lui_neg", 32'h80000037, 64'h80000000, 3'(FMT_U), 1'b0};
        v32[6] = '{"csrrwi",  32'h3402D073, 64'h00000005, 3'(FMT_Z), 1'b0};
        v32[7] = '{"csrrw",   32'h34029073, 64'h00000000, 3'(FMT_NONE), 1'b0};
        v32[8] = '{"bad_opc", 32'h0000007F, 64'h00000000, 3'(FMT_NONE), 1'b1};
`ifdef IMM_GEN_RVC_EN
        v32[9] = '{"c_li",    32'h00004505, 64'h00000001, 3'(FMT_C), 1'b0};
`else
        v32[9] = '{"c_li",    32'h00004505, 64'h00000000, 3'(FMT_NONE), 1'b1};
`endif
        v64[0] = '{"lui64",    32'h80000037, 64'hFFFFFFFF80000000, 3'(FMT_U), 1'b0};
        v64[1] = '{"csrrwi64", 32'h3402D073, 64'h0000000000000005, 3'(FMT_Z), 1'b0};
        v64[2] = '{"addi64",   32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'(FMT_I), 1'b0};

        rst_n           = 1'b0;
        bus32.in_valid  = 1'b0;
        bus32.in_inst   = '0;
        bus32.out_ready = 1'b0;
        bus64.in_valid  = 1'b0;
        bus64.in_inst   = '0;
        bus64.out_ready = 1'b1;

        // Power-on reset values
        #12;
        check("rst_out_valid", 64'(bus32.out_valid), 64'(1'b0));
        check("rst_in_ready",  64'(bus32.in_ready),  64'(1'b0));
        check("rst_imm",       64'(bus32.out_imm),   64'h0);
        check("rst_fmt",       64'(bus32.out_fmt),   64'(FMT_NONE));
        check("rst_ill",       64'(bus32.out_illegal), 64'(1'b0));
        rst_n = 1'b1;
        #1;
        check("rel_in_ready_low", 64'(bus32.in_ready), 64'(1'b0));
        tick();
        check("rel_in_ready_high", 64'(bus32.in_ready), 64'(1'b1));

        // Streaming decode with the consumer always ready
        bus32.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus32.in_valid = 1'b1;
            bus32.in_inst  = v32[i].inst;
            tick();
            check32(v32[i].name, v32[i]);
        end
        bus32.in_valid = 1'b0;
        tick();
        check("drain_valid", 64'(bus32.out_valid), 64'(1'b0));

        // Backpressure: three words offered while the consumer stalls
        bus32.out_ready = 1'b0;
        bus32.in_valid  = 1'b1;
        bus32.in_inst   = v32[0].inst;
        tick();
        check("bp_ready_a", 64'(bus32.in_ready), 64'(1'b1));
        bus32.in_inst = v32[3].inst;
        tick();
        check("bp_ready_full", 64'(bus32.in_ready), 64'(1'b0));
        bus32.in_inst = v32[4].inst;
        tick();
        check("bp_ready_hold", 64'(bus32.in_ready), 64'(1'b0));
        check32("bp_hold_a", v32[0]);
        bus32.out_ready = 1'b1;
        tick();
        check32("bp_out_b", v32[3]);
        check("bp_ready_back", 64'(bus32.in_ready), 64'(1'b1));
        tick();
        bus32.in_valid = 1'b0;
        check32("bp_out_c", v32[4]);
        tick();
        check("bp_empty", 64'(bus32.out_valid), 64'(1'b0));

        // Reset while the buffer is full
        bus32.out_ready = 1'b0;
        bus32.in_valid  = 1'b1;
        bus32.in_inst   = v32[1].inst;
        tick();
        bus32.in_inst = v32[2].inst;
        tick();
        bus32.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(bus32.out_valid), 64'(1'b0));
        check("mid_rst_ready", 64'(bus32.in_ready),  64'(1'b0));
        check("mid_rst_imm",   64'(bus32.out_imm),   64'h0);
        #2;
        rst_n = 1'b1;
        #1;
        check("mid_rel_ready_low", 64'(bus32.in_ready), 64'(1'b0));
        tick();
        check("mid_rel_ready_high", 64'(bus32.in_ready), 64'(1'b1));
        check("mid_rel_no_stale", 64'(bus32.out_valid), 64'(1'b0));
        bus32.out_ready = 1'b1;
        tick();
        check("mid_rel_still_empty", 64'(bus32.out_valid), 64'(1'b0));

        // 64-bit instance: sign extension across the full width
        for (int i = 0; i < 3; i++) begin
            bus64.in_valid = 1'b1;
            bus64.in_inst  = v64[i].inst;
            tick();
            check({v64[i].name, "_valid"}, 64'(bus64.out_valid), 64'(1'b1));
            check({v64[i].name, "_imm"},   bus64.out_imm,        v64[i].imm);
            check({v64[i].name, "_fmt"},   64'(bus64.out_fmt),   64'(v64[i].fmt));
            check({v64[i].name, "_ill"},   64'(bus64.out_illegal), 64'(v64[i].ill));
        end
        bus64.in_valid = 1'b0;
        tick();
        check("d64_drain", 64'(bus64.out_valid), 64'(1'b0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
